nested_index_counter: RTL and testbench
=======================================

Name: nested_index_counter

Overview:
- Two-level programmable index sequencer for neural-net layer iteration.
- The inner index walks neuron inputs; the outer index walks neurons/rows.
- Generalises the fixed 4-bit free-running counter in three ways: parametrised widths, run-time terminal values, and a start/busy/done run protocol.
- Sits between the layer controller (issues start, increment per MAC) and weight/activation address generation (consumes the indices).

Parameters:
- INNER_WIDTH, 4, width of inner index and inner_limit.
- OUTER_WIDTH, 4, width of outer index and outer_limit.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- clear  input  1  synchronous abort: counts to 0, state to IDLE.
- start  input  1  begin a run; sampled only in IDLE.
- increment  input  1  advance one index step; sampled only in RUN.
- inner_limit  input  INNER_WIDTH  last inner index (inclusive); latched on start.
- outer_limit  input  OUTER_WIDTH  last outer index (inclusive); latched on start.
- inner_count  output  INNER_WIDTH  current inner index.
- outer_count  output  OUTER_WIDTH  current outer index.
- inner_last  output  1  inner_count == latched inner limit.
- outer_last  output  1  outer_count == latched outer limit.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final step.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - inner_count = 0, outer_count = 0.
  - Latched limits = 0.
  - busy = 0, done = 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from registers; no input-to-output combinational path.
- IDLE:
  - Counts hold.
  - start = 1: latch both limits, force counts to 0, go to RUN next cycle.
  - increment is ignored.
- RUN:
  - busy = 1.
  - increment = 0: counts hold.
  - increment = 1 and not inner_last: inner_count + 1.
  - increment = 1 and inner_last and not outer_last: inner_count -> 0, outer_count + 1.
  - increment = 1 and inner_last and outer_last: both counts -> 0, go to DONE.
  - start is ignored.
- DONE:
  - Lasts exactly one cycle; done = 1, busy = 0.
  - Returns to IDLE unconditionally; start in this cycle is ignored.
- A run takes exactly (inner_limit+1)*(outer_limit+1) accepted increments.
- Limit 0 on a dimension means a single index in that dimension. Both limits 0: the first increment ends the run.
- Changes to the limit inputs during RUN have no effect; the latched copies are used.
- inner_last and outer_last compare against the latched limits and are valid in every state. After reset, both flags are 1 (0 == 0).
- clear is synchronous and overrides start and increment in any state:
  - Counts -> 0, state -> IDLE, done = 0.
  - Latched limits are retained.
- Reset asserted mid-run: immediate return to reset values; no done pulse.
- Counters never wrap past their latched limit; width overflow is impossible because limits fit the width.

Decomposition:
- Shared package: FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) for reuse by the layer controller and bench.
- One sub-module, param_limit_counter (parameter WIDTH), instantiated twice.
  - Ports: clock, reset, clear, increment, limit, count, last.
  - Behaviour: wraps to 0 on increment when last; clear has priority.
  - The outer instance's increment = top-level increment & inner_last in RUN.

Test Plan:
- Reset mid-count (inner = 2, outer = 1) -> next sample: counts 0, busy = 0, done = 0; no done pulse.
- start with inner_limit = 2, outer_limit = 1, then increment held high -> (inner,outer) sequence (0,0) (1,0) (2,0) (0,1) (1,1) (2,1). The 6th increment gives done = 1 for one cycle, then IDLE with counts 0.
- Both limits 0, start, single increment -> done pulses the cycle after; busy high for exactly 1 cycle.
- In RUN, toggle increment 1,0,0,1 and change inner_limit from 3 to 1 -> counts advance only on increment = 1; wrap still occurs at the latched 3.
- Defaults, limits 15/15, 256 increments -> inner_last/outer_last both high before the 256th increment, done after it, no overflow.
- clear asserted at (inner,outer) = (1,1) with increment = 1 and start = 1 -> counts 0, IDLE, busy = 0, no done pulse. A following start restarts cleanly.

Source files
------------

// File: rtl/nested_index_counter_pkg.sv
// Shared definitions for the nested index sequencer: FSM state encoding
// used by the sequencer, the layer controller and the bench.
package nested_index_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_INNER_WIDTH = 4;
   localparam int DEFAULT_OUTER_WIDTH = 4;

endpackage : nested_index_counter_pkg

// File: rtl/nested_index_counter_limit_counter.sv
// Single-dimension index counter with a run-time terminal value.
// Counts 0..limit inclusive and wraps to 0 on the increment that finds it at
// the limit. clear forces the count to 0 and wins over increment.
module param_limit_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             increment,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   // Index register: clear first, then wrap-or-advance on increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (increment) begin
         if (last) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // Terminal flag is decoded from registers only (count and latched limit).
   always_comb begin
      last = (count == limit);
   end

endmodule : param_limit_counter

// File: rtl/nested_index_counter.sv
// Two-level programmable index sequencer for layer iteration.
// The inner index walks neuron inputs, the outer index walks neurons/rows.
// A run is started from IDLE, advanced by increment in RUN, and finishes with
// a single-cycle DONE state after (inner_limit+1)*(outer_limit+1) steps.
module nested_index_counter
   import nested_index_counter_pkg::*;
#(
   parameter int INNER_WIDTH = DEFAULT_INNER_WIDTH,
   parameter int OUTER_WIDTH = DEFAULT_OUTER_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   start,
   input  logic                   increment,
   input  logic [INNER_WIDTH-1:0] inner_limit,
   input  logic [OUTER_WIDTH-1:0] outer_limit,
   output logic [INNER_WIDTH-1:0] inner_count,
   output logic [OUTER_WIDTH-1:0] outer_count,
   output logic                   inner_last,
   output logic                   outer_last,
   output logic                   busy,
   output logic                   done
);

   state_t                 state;
   state_t                 state_next;
   logic [INNER_WIDTH-1:0] inner_limit_latched;
   logic [OUTER_WIDTH-1:0] outer_limit_latched;
   logic                   start_accept;
   logic                   count_clear;
   logic                   inner_step;
   logic                   outer_step;

   // Decode the qualified control strobes; clear overrides start and increment.
   always_comb begin
      start_accept = (state == IDLE) && start && !clear;
      count_clear  = clear || start_accept;
      inner_step   = (state == RUN) && increment && !clear;
      outer_step   = inner_step && inner_last;
   end

   // Limits are captured only when a run is accepted and survive clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inner_limit_latched <= '0;
         outer_limit_latched <= '0;
      end else if (start_accept) begin
         inner_limit_latched <= inner_limit;
         outer_limit_latched <= outer_limit;
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: the final step of the final row ends the run.
   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (increment && inner_last && outer_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Status outputs decoded purely from the state register.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Inner index: advances on every accepted increment.
   param_limit_counter #(
      .WIDTH(INNER_WIDTH)
   ) inner_counter (
      .clock     (clock),
      .reset     (reset),
      .clear     (count_clear),
      .increment (inner_step),
      .limit     (inner_limit_latched),
      .count     (inner_count),
      .last      (inner_last)
   );

   // Outer index: advances when the inner index wraps.
   param_limit_counter #(
      .WIDTH(OUTER_WIDTH)
   ) outer_counter (
      .clock     (clock),
      .reset     (reset),
      .clear     (count_clear),
      .increment (outer_step),
      .limit     (outer_limit_latched),
      .count     (outer_count),
      .last      (outer_last)
   );

endmodule : nested_index_counter

// File: tb/tb_nested_index_counter.sv
// Directed bench for nested_index_counter: a vector table for the main
// sequences plus hand-written reset, clear and full-range runs.
module tb_nested_index_counter;

   logic       clock;
   logic       reset;
   logic       clear;
   logic       start;
   logic       increment;
   logic [3:0] inner_limit;
   logic [3:0] outer_limit;
   logic [3:0] inner_count;
   logic [3:0] outer_count;
   logic       inner_last;
   logic       outer_last;
   logic       busy;
   logic       done;

   int compared;
   int mismatched;

   typedef struct {
      logic       clr;
      logic       st;
      logic       inc;
      logic [3:0] il;
      logic [3:0] ol;
      logic [3:0] e_inner;
      logic [3:0] e_outer;
      logic       e_il;
      logic       e_ol;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vecs[21];

   nested_index_counter #(
      .INNER_WIDTH(4),
      .OUTER_WIDTH(4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .start       (start),
      .increment   (increment),
      .inner_limit (inner_limit),
      .outer_limit (outer_limit),
      .inner_count (inner_count),
      .outer_count (outer_count),
      .inner_last  (inner_last),
      .outer_last  (outer_last),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] ei, input logic [3:0] eo,
                            input logic eil, input logic eol, input logic eb, input logic ed);
      check({tag, ".inner_count"}, int'(inner_count), int'(ei));
      check({tag, ".outer_count"}, int'(outer_count), int'(eo));
      check({tag, ".inner_last"},  int'(inner_last),  int'(eil));
      check({tag, ".outer_last"},  int'(outer_last),  int'(eol));
      check({tag, ".busy"},        int'(busy),        int'(eb));
      check({tag, ".done"},        int'(done),        int'(ed));
      $display("%s: in=%0d out=%0d il=%0b ol=%0b busy=%0b done=%0b", tag,
               inner_count, outer_count, inner_last, outer_last, busy, done);
   endtask

   task automatic drive(input logic c, input logic s, input logic i,
                        input logic [3:0] il, input logic [3:0] ol);
      clear = c; start = s; increment = i; inner_limit = il; outer_limit = ol;
   endtask

   initial begin
      int done_seen;
      compared   = 0;
      mismatched = 0;

      //          clr st inc il ol  inner outer il ol busy done
      // Run with limits 2/1, increment held high.
      vecs[0]  = '{0, 1, 0, 2, 1, 0, 0, 0, 0, 1, 0};
      vecs[1]  = '{0, 0, 1, 2, 1, 1, 0, 0, 0, 1, 0};
      vecs[2]  = '{0, 0, 1, 2, 1, 2, 0, 1, 0, 1, 0};
      vecs[3]  = '{0, 0, 1, 2, 1, 0, 1, 0, 1, 1, 0};
      vecs[4]  = '{0, 0, 1, 2, 1, 1, 1, 0, 1, 1, 0};
      vecs[5]  = '{0, 0, 1, 2, 1, 2, 1, 1, 1, 1, 0};
      vecs[6]  = '{0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1};
      vecs[7]  = '{0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0};  // start in DONE ignored
      vecs[8]  = '{0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0};
      // Limits 3/1 latched; inner_limit changed to 1 mid-run; gapped increments.
      vecs[9]  = '{0, 1, 0, 3, 1, 0, 0, 0, 0, 1, 0};
      vecs[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0};
      vecs[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
      vecs[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
      vecs[13] = '{0, 0, 1, 1, 1, 2, 0, 0, 0, 1, 0};
      vecs[14] = '{0, 0, 1, 1, 1, 3, 0, 1, 0, 1, 0};
      vecs[15] = '{0, 0, 1, 1, 1, 0, 1, 0, 1, 1, 0};
      vecs[16] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0};  // start in RUN ignored
      vecs[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // clear keeps limits 3/1
      // Both limits 0: the first increment ends the run.
      vecs[18] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      vecs[19] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1};
      vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_all("reset_state", 0, 0, 1, 1, 0, 0);

      for (int v = 0; v < 21; v++) begin
         drive(vecs[v].clr, vecs[v].st, vecs[v].inc, vecs[v].il, vecs[v].ol);
         tick();
         check_all($sformatf("vec%0d", v), vecs[v].e_inner, vecs[v].e_outer,
                   vecs[v].e_il, vecs[v].e_ol, vecs[v].e_busy, vecs[v].e_done);
      end

      // Clear at (1,1) with increment and start asserted, then restart.
      drive(0, 1, 0, 1, 2);
      tick();
      drive(0, 0, 1, 1, 2);
      tick();
      tick();
      tick();
      drive(0, 0, 0, 1, 2);
      check_all("pre_clear", 1, 1, 1, 0, 1, 0);
      drive(1, 1, 1, 1, 2);
      tick();
      check_all("clear", 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 2);
      tick();
      check_all("after_clear", 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 0);
      tick();
      check_all("restart", 0, 0, 0, 1, 1, 0);
      drive(0, 0, 1, 1, 0);
      tick();
      check_all("restart_step1", 1, 0, 1, 1, 1, 0);
      tick();
      check_all("restart_done", 0, 0, 0, 1, 0, 1);
      drive(0, 0, 0, 1, 0);
      tick();
      check_all("restart_idle", 0, 0, 0, 1, 0, 0);

      // Asynchronous reset mid-count at (2,1): no done pulse afterwards.
      drive(0, 1, 0, 2, 1);
      tick();
      drive(0, 0, 1, 2, 1);
      for (int k = 0; k < 5; k++) tick();
      drive(0, 0, 0, 2, 1);
      check_all("pre_reset", 2, 1, 1, 1, 1, 0);
      #2 reset = 1'b1;
      #1;
      check_all("async_reset", 0, 0, 1, 1, 0, 0);
      tick();
      reset = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done || busy) done_seen++;
      end
      check("reset_no_done", done_seen, 0);

      // Full range 15/15: 256 increments.
      drive(0, 1, 0, 15, 15);
      tick();
      drive(0, 0, 1, 15, 15);
      done_seen = 0;
      for (int k = 0; k < 255; k++) begin
         tick();
         if (done || !busy) done_seen++;
      end
      check("full_no_early_end", done_seen, 0);
      check_all("full_before_last", 15, 15, 1, 1, 1, 0);
      tick();
      check_all("full_done", 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 15, 15);
      tick();
      check_all("full_idle", 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_nested_index_counter
